// File: rtl/game_pkg.sv
// Shared types and constants for the frog-game state controller: FSM state
// encoding, mux select codes and default sound codes.
package game_pkg;

  typedef enum logic [2:0] {
    PLAY,
    WIN,
    LOSE,
    BUZ,
    OVER
  } game_state_e;

  localparam logic [7:0] BACKGROUND = 8'd0;

  localparam logic [9:0] WIN_FREQ_DEFAULT  = 10'd1;
  localparam logic [9:0] LOSE_FREQ_DEFAULT = 10'd0;

  // The player code sits just past the last object code.
  function automatic logic [7:0] player_code(input int num_obj);
    return 8'(num_obj + 1);
  endfunction

endpackage

// File: rtl/obj_priority_sel.sv
// Combinational draw-priority encoder: object 0 wins, with the player slotted
// in just above object PLAYER_PRIO. No request selects the background.
module obj_priority_sel
  import game_pkg::*;
#(
  parameter int NUM_OBJ     = 5,
  parameter int PLAYER_PRIO = 3
) (
  input  logic [NUM_OBJ-1:0] draw_req,
  input  logic               player_draw_req,
  output logic [7:0]         select_mux
);

  // Lowest priority is written first so later, higher-priority hits override.
  // NOTE: select_mux is assigned before any condition so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    select_mux = BACKGROUND;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (i >= PLAYER_PRIO && draw_req[i]) select_mux = 8'(i + 1);
    end
    if (player_draw_req) select_mux = player_code(NUM_OBJ);
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (i < PLAYER_PRIO && draw_req[i]) select_mux = 8'(i + 1);
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Frog-game state controller: pixel mux select, win/lose detection, level and
// log mask, sound window. Define GAME_LIVES_EN to add lives and the OVER state.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int               NUM_OBJ     = 5,
  parameter logic [NUM_OBJ-1:0] HAZARD_MASK = 5'b00111,
  parameter int               GOAL_IDX    = 4,
  parameter int               PLAYER_PRIO = 3,
  parameter int               LOG_NUM     = 100,
  parameter int               LOG_STEP    = 5,
  parameter int               MAX_LEVEL   = 4,
  parameter int               BUZ_CYCLES  = 50000000,
  parameter logic [9:0]       WIN_FREQ    = WIN_FREQ_DEFAULT,
  parameter logic [9:0]       LOSE_FREQ   = LOSE_FREQ_DEFAULT,
  parameter int               LIVES       = 3,
  localparam int              LW          = $clog2(MAX_LEVEL + 1)
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic [NUM_OBJ-1:0] draw_req,
  input  logic               player_draw_req,
  input  logic               restart,
  output logic [7:0]         select_mux,
  output logic               win,
  output logic               lose,
  output logic [LW-1:0]      level,
  output logic [LOG_NUM-1:0] log_enable_out,
  output logic [9:0]         sound_freq_out,
  output logic               enable_sound,
  output logic [LW-1:0]      lives_left,
  output logic               game_over
);

  localparam int                 CW        = $clog2(BUZ_CYCLES + 1);
  localparam logic [CW-1:0]      BUZ_LOAD  = CW'(BUZ_CYCLES - 1);
  localparam logic [LW-1:0]      LVL_MIN   = LW'(1);
  localparam logic [LW-1:0]      LVL_MAX   = LW'(MAX_LEVEL);
  localparam logic [LOG_NUM-1:0] STEP_ONES = {{(LOG_NUM - LOG_STEP){1'b0}}, {LOG_STEP{1'b1}}};

  game_state_e        state_q, state_d;
  logic [LW-1:0]      level_q;
  logic [LOG_NUM-1:0] mask_q;
  logic [9:0]         freq_q;
  logic [CW-1:0]      buz_cnt_q;
  logic               hit_lose, hit_win;

  obj_priority_sel #(
    .NUM_OBJ    (NUM_OBJ),
    .PLAYER_PRIO(PLAYER_PRIO)
  ) u_prio (
    .draw_req       (draw_req),
    .player_draw_req(player_draw_req),
    .select_mux     (select_mux)
  );

  assign hit_lose = player_draw_req & (|(draw_req & HAZARD_MASK));
  assign hit_win  = player_draw_req & draw_req[GOAL_IDX];

`ifdef GAME_LIVES_EN
  logic [LW-1:0] lives_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lives_q <= LW'(LIVES);
    end else if (state_q == LOSE) begin
      lives_q <= lives_q - 1'b1;
    end else if (state_q == OVER && restart) begin
      lives_q <= LW'(LIVES);
    end
  end

  assign lives_left = lives_q;
  assign game_over  = (state_q == OVER);
`else
  logic unused_restart;
  assign unused_restart = restart | (LIVES == 0);
  assign lives_left     = '0;
  assign game_over      = 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state_q <= PLAY;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PLAY: begin
        if (hit_lose)     state_d = LOSE;
        else if (hit_win) state_d = WIN;
      end
      WIN: state_d = BUZ;
      LOSE: begin
        state_d = BUZ;
`ifdef GAME_LIVES_EN
        if (lives_q == LW'(1)) state_d = OVER;
`endif
      end
      BUZ: begin
        if (buz_cnt_q == '0) state_d = PLAY;
      end
      OVER: begin
`ifdef GAME_LIVES_EN
        if (restart) state_d = PLAY;
`else
        state_d = PLAY;
`endif
      end
      default: state_d = PLAY;
    endcase
  end

  // Level, mask and sound code change only on the single WIN/LOSE cycle, so
  // the new values appear together with the first BUZ cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      level_q   <= LVL_MIN;
      mask_q    <= '0;
      freq_q    <= LOSE_FREQ;
      buz_cnt_q <= '0;
    end else begin
      unique case (state_q)
        WIN: begin
          freq_q    <= WIN_FREQ;
          buz_cnt_q <= BUZ_LOAD;
          if (level_q < LVL_MAX) begin
            level_q <= level_q + 1'b1;
            mask_q  <= (mask_q << LOG_STEP) | STEP_ONES;
          end
        end
        LOSE: begin
          freq_q    <= LOSE_FREQ;
          buz_cnt_q <= BUZ_LOAD;
          if (level_q > LVL_MIN) begin
            level_q <= level_q - 1'b1;
            mask_q  <= mask_q >> LOG_STEP;
          end
        end
        BUZ: begin
          if (buz_cnt_q != '0) buz_cnt_q <= buz_cnt_q - 1'b1;
        end
        OVER: begin
          if (restart) begin
            level_q <= LVL_MIN;
            mask_q  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign win            = (state_q == WIN);
  assign lose           = (state_q == LOSE);
  assign enable_sound   = (state_q == BUZ);
  assign level          = level_q;
  assign log_enable_out = mask_q;
  assign sound_freq_out = freq_q;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Self-checking bench for game_state_ctrl: directed scenarios plus random
// stimulus, compared every cycle against a game-rule model.
module tb_game_state_ctrl;

  localparam int NUM_OBJ     = 5;
  localparam int PLAYER_PRIO = 3;
  localparam int BUZ         = 5;
  localparam int MAXL        = 4;
  localparam int STEP        = 5;
  localparam int LOGN        = 100;
  localparam int LIVES       = 3;
  localparam int LW          = 3;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic [4:0]         draw_req = '0;
  logic               player_draw_req = 1'b0;
  logic               restart = 1'b0;
  logic [7:0]         select_mux;
  logic               win, lose, enable_sound, game_over;
  logic [LW-1:0]      level, lives_left;
  logic [LOGN-1:0]    log_enable_out;
  logic [9:0]         sound_freq_out;

  game_state_ctrl #(.BUZ_CYCLES(BUZ)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .draw_req       (draw_req),
    .player_draw_req(player_draw_req),
    .restart        (restart),
    .select_mux     (select_mux),
    .win            (win),
    .lose           (lose),
    .level          (level),
    .log_enable_out (log_enable_out),
    .sound_freq_out (sound_freq_out),
    .enable_sound   (enable_sound),
    .lives_left     (lives_left),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Walk sources from the top of the draw order and take the first one lit.
  function automatic logic [7:0] exp_sel(input logic [4:0] d, input logic p);
    for (int k = 0; k <= NUM_OBJ; k++) begin
      if (k < PLAYER_PRIO) begin
        if (d[k]) return 8'(k + 1);
      end else if (k == PLAYER_PRIO) begin
        if (p) return 8'(NUM_OBJ + 1);
      end else begin
        if (d[k-1]) return 8'(k);
      end
    end
    return 8'd0;
  endfunction

  function automatic logic [LOGN-1:0] exp_mask(input int lvl);
    logic [LOGN-1:0] m;
    m = '0;
    for (int i = 0; i < STEP * (lvl - 1) && i < LOGN; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Game-rule model: pending event (0 none, 1 win, 2 lose), remaining sound
  // cycles, game-over flag, level, lives and last sound code.
  int         m_level = 1;
  int         m_lives = LIVES;
  int         m_buzz  = 0;
  int         m_pend  = 0;
  logic       m_over  = 1'b0;
  logic [9:0] m_freq  = 10'd0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_level <= 1;
      m_lives <= LIVES;
      m_buzz  <= 0;
      m_pend  <= 0;
      m_over  <= 1'b0;
      m_freq  <= 10'd0;
    end else if (m_pend == 1) begin
      m_pend <= 0;
      m_freq <= 10'd1;
      m_buzz <= BUZ;
      if (m_level < MAXL) m_level <= m_level + 1;
    end else if (m_pend == 2) begin
      m_pend <= 0;
      m_freq <= 10'd0;
      if (m_level > 1) m_level <= m_level - 1;
`ifdef GAME_LIVES_EN
      if (m_lives == 1) begin
        m_lives <= 0;
        m_over  <= 1'b1;
      end else begin
        m_lives <= m_lives - 1;
        m_buzz  <= BUZ;
      end
`else
      m_buzz <= BUZ;
`endif
    end else if (m_buzz > 0) begin
      m_buzz <= m_buzz - 1;
    end else if (m_over) begin
      if (restart) begin
        m_over  <= 1'b0;
        m_lives <= LIVES;
        m_level <= 1;
      end
    end else if (player_draw_req && (draw_req & 5'b00111) != 0) begin
      m_pend <= 2;
    end else if (player_draw_req && draw_req[4]) begin
      m_pend <= 1;
    end
  end

  always @(negedge clk) begin
    check("select_mux", select_mux, exp_sel(draw_req, player_draw_req));
    check("win", win, m_pend == 1);
    check("lose", lose, m_pend == 2);
    check("enable_sound", enable_sound, m_buzz > 0);
    check("level", level, m_level);
    check("log_enable_out", log_enable_out, exp_mask(m_level));
    check("sound_freq_out", sound_freq_out, m_freq);
`ifdef GAME_LIVES_EN
    check("lives_left", lives_left, m_lives);
    check("game_over", game_over, m_over);
`else
    check("lives_left", lives_left, 0);
    check("game_over", game_over, 1'b0);
`endif
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input logic [4:0] d, input logic p);
    draw_req        = d;
    player_draw_req = p;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    cyc(2);
    resetN = 1'b1;
    cyc(1);
  endtask

  task automatic count_window(input int n, output int nw, output int nl, output int ns);
    nw = 0;
    nl = 0;
    ns = 0;
    repeat (n) begin
      @(negedge clk);
      nw += int'(win);
      nl += int'(lose);
      ns += int'(enable_sound);
    end
    #2;
  endtask

  int nw, nl, ns;

  initial begin
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    cyc(1);
    check("reset_level", level, 1);
    check("reset_mask", log_enable_out, 0);
    check("reset_freq", sound_freq_out, 0);

    // Hazard object 2 under the player: object wins the pixel, one loss.
    drive(5'b00100, 1'b1);
    #1 check("t1_select", select_mux, 3);
    cyc(1);
    drive(5'b00000, 1'b0);
    count_window(12, nw, nl, ns);
    check("t1_lose_pulses", nl, 1);
    check("t1_win_pulses", nw, 0);
    check("t1_sound_cycles", ns, 5);
    check("t1_level", level, 1);
    check("t1_mask", log_enable_out, 0);

    // Goal only: win, level 2, five lit mask bits.
    drive(5'b10000, 1'b1);
    cyc(1);
    drive(5'b00000, 1'b0);
    count_window(12, nw, nl, ns);
    check("t2_win_pulses", nw, 1);
    check("t2_sound_cycles", ns, 5);
    check("t2_level", level, 2);
    check("t2_mask", log_enable_out, 31);
    check("t2_freq", sound_freq_out, 1);
    check("t2_back_in_play", enable_sound, 1'b0);

    // Hazard and goal together: loss wins the tie.
    drive(5'b10001, 1'b1);
    cyc(1);
    drive(5'b00000, 1'b0);
    count_window(12, nw, nl, ns);
    check("t3_lose_pulses", nl, 1);
    check("t3_win_pulses", nw, 0);
    check("t3_level", level, 1);

    // Level saturation, then one step down.
    do_reset();
    repeat (4) begin
      drive(5'b10000, 1'b1);
      cyc(1);
      drive(5'b00000, 1'b0);
      cyc(8);
    end
    check("t4_level_sat", level, 4);
    check("t4_mask_sat", log_enable_out, 128'h7fff);
    drive(5'b00001, 1'b1);
    cyc(1);
    drive(5'b00000, 1'b0);
    cyc(8);
    check("t4_level_down", level, 3);
    check("t4_mask_down", log_enable_out, 128'h3ff);
    check("t4_freq", sound_freq_out, 0);

    // Hazard held continuously: one loss per return to PLAY.
    do_reset();
    drive(5'b00010, 1'b1);
    count_window(20, nw, nl, ns);
    drive(5'b00000, 1'b0);
    check("t5_lose_pulses", nl, 3);
    check("t5_win_pulses", nw, 0);
`ifdef GAME_LIVES_EN
    check("t5_game_over", game_over, 1'b1);
    check("t5_lives", lives_left, 0);
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
    check("t5_restart_over", game_over, 1'b0);
    check("t5_restart_lives", lives_left, 3);
    check("t5_restart_level", level, 1);
`else
    check("t5_no_over", game_over, 1'b0);
    check("t5_no_lives", lives_left, 0);
`endif

    // Reset in the middle of a sound window.
    cyc(8);
    drive(5'b10000, 1'b1);
    cyc(1);
    drive(5'b00000, 1'b0);
    cyc(2);
    check("t6_in_buz", enable_sound, 1'b1);
    resetN = 1'b0;
    #1;
    check("t6_reset_level", level, 1);
    check("t6_reset_sound", enable_sound, 1'b0);
    check("t6_reset_mask", log_enable_out, 0);
    cyc(1);
    resetN = 1'b1;
    cyc(1);

    // Random play, compared against the model every cycle.
    repeat (3000) begin
      draw_req        = 5'($urandom);
      player_draw_req = 1'($urandom_range(0, 1));
      restart         = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 499) == 0) begin
        resetN = 1'b0;
        cyc(1);
        resetN = 1'b1;
      end
      cyc(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
